mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: cycles to wait for mem_ack before aborting an access (legal range 1..255).
REQ-002 Parameter STARVE_MAX, default 2: consecutive data grants allowed while fetch is pending.
REQ-003 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Ports if_req (in, 1) and if_addr (in, 32): instruction-fetch request and word address.
REQ-006 Ports if_rdata (out, 32) and if_done (out, 1): fetched word and one-cycle completion pulse.
REQ-007 Ports d_req (in, 1), d_we (in, 1), d_addr (in, 32) and d_wdata (in, 32): data load/store request, write enable, address and store data.
REQ-008 Ports d_rdata (out, 32) and d_done (out, 1): load data and one-cycle completion pulse.
REQ-009 Ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32) and mem_wdata (out, 32): shared single-port memory request.
REQ-010 Ports mem_rdata (in, 32) and mem_ack (in, 1): memory read data, valid in the mem_ack cycle.
REQ-011 Port err (out, 1): pulses together with if_done or d_done when the access timed out.

Function
REQ-012 FSM states: IDLE, GNT_IF, GNT_D and RESP; all outputs are registered.
REQ-013 IDLE, no request pending: stay in IDLE with mem_req=0.
REQ-014 IDLE, only d_req high: go to GNT_D.
REQ-015 IDLE, only if_req high: go to GNT_IF.
REQ-016 IDLE, both requests high: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-017 On grant, mem_addr, mem_we and mem_wdata latch from the winner; the fetch winner forces mem_we=0 and mem_wdata=0; mem_req=1 from the next cycle onward.
REQ-018 starve_cnt (2-bit saturating) increments on each data grant made while if_req=1, and clears on any fetch grant or when if_req=0 at a grant decision.
REQ-019 GNT_x: hold mem_req and the latched fields stable until mem_ack; requester input changes are ignored.
REQ-020 GNT_x with mem_ack=1: latch mem_rdata into the served requester's rdata (d_rdata is loaded for loads only; stores leave it unchanged), drop mem_req, go to RESP.
REQ-021 RESP: lasts exactly one cycle; the served requester's done=1; then go to IDLE; requests are not sampled in RESP.
REQ-022 Latency: request high in IDLE at cycle 0 gives mem_req=1 at cycle 1; mem_ack at cycle k gives done at cycle k+1 and IDLE at cycle k+2.
REQ-023 Requester handshake: req and operands are held until done; req is deasserted in the done cycle or re-requested afterwards; a req still high in IDLE is a new request.
REQ-024 Timeout: tmo_cnt counts GNT_x cycles without mem_ack.
REQ-025 On reaching TIMEOUT, drop mem_req, go to RESP, pulse done and err=1, and load rdata=0 for reads.
REQ-026 mem_ack in the same cycle the count reaches TIMEOUT is a normal completion (ack wins) with err=0.
REQ-027 mem_ack outside GNT_x is ignored.
REQ-028 if_done and d_done are never high in the same cycle; mem_req is never high in IDLE or RESP.

Reset
REQ-029 reset=1 at an edge forces IDLE and zeroes mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done, err, starve_cnt and tmo_cnt, even mid-access (the pending access is dropped with no done pulse).
REQ-030 First request is sampled in the first IDLE cycle after reset deasserts.

Verification
REQ-031 Fetch: if_req=1, if_addr=0x00000010; ack at cycle 3 with rdata=0x00A00093 -> mem_req cycles 1-3, if_done=1 and if_rdata=0x00A00093 at cycle 4, err=0.
REQ-032 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; d_done one cycle after ack; d_rdata unchanged.
REQ-033 Contention: if_req and d_req held high, ack always 1 cycle after mem_req -> grant order D, D, IF, D, D, IF.
REQ-034 Timeout: d_req load, mem_ack never asserted, TIMEOUT=15 -> mem_req high 15 cycles, then d_done=1, err=1, d_rdata=0; ack at count 15 -> err=0.
REQ-035 Reset mid-access: reset in GNT_IF cycle 2 -> next cycle mem_req=0, all outputs 0, no if_done; a new if_req is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory port.
// The slave view is the arbiter; the master view drives requests and models the memory.
interface mem_port_arbiter_if;
  // Instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;

  // Data load/store requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;

  // Shared single-port memory
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data accesses.
// Data normally wins; fetch is guaranteed a grant after STARVE_MAX data grants in a row.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned STARVE_MAX = 2
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] TmoMax    = 8'(TIMEOUT);
  localparam logic [1:0] StarveMax = 2'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntIf = 2'd1,
    StGntD  = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic        err_q, err_d;
  logic [1:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        fetch_wins;
  logic        tmo_hit;

  // Fetch takes the port when alone, or when data has already starved it long enough.
  assign fetch_wins = bus.if_req && (!bus.d_req || (starve_cnt_q == StarveMax));
  assign tmo_hit    = (tmo_cnt_q + 8'd1) == TmoMax;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    err_d        = 1'b0;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_wins) begin
          state_d      = StGntIf;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
          tmo_cnt_d    = '0;
        end else if (bus.d_req) begin
          state_d     = StGntD;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          tmo_cnt_d   = '0;
          if (!bus.if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != 2'd3) begin
            starve_cnt_d = starve_cnt_q + 2'd1;
          end
        end
      end

      StGntIf, StGntD: begin
        // An ack arriving in the same cycle as the timeout still completes normally.
        if (bus.mem_ack) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          tmo_cnt_d = '0;
          if (state_q == StGntIf) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end else if (tmo_hit) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          tmo_cnt_d = '0;
          err_d     = 1'b1;
          if (state_q == StGntIf) begin
            if_done_d  = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = '0;
            end
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;

  a_done_exclusive : assert property (@(posedge clock) disable iff (reset)
    !(if_done_q && d_done_q));

  a_no_req_outside_grant : assert property (@(posedge clock) disable iff (reset)
    (state_q inside {StIdle, StResp}) |-> !mem_req_q);

  a_err_with_done : assert property (@(posedge clock) disable iff (reset)
    err_q |-> (if_done_q || d_done_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model:
// grant winner from the starvation rule, completion from the ack-or-timeout rule.
module tb_mem_port_arbiter;
  localparam int unsigned TIMEOUT    = 15;
  localparam int unsigned STARVE_MAX = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int          starve       = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;

  logic        got_if;
  logic [5:0]  order;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT   (TIMEOUT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
    check_eq({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check_eq({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    check_eq({tag, "_if_rdata"},  bus.if_rdata,       32'd0);
    check_eq({tag, "_d_rdata"},   bus.d_rdata,        32'd0);
    check_eq({tag, "_dones"},     32'({bus.if_done, bus.d_done}), 32'd0);
    check_eq({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  // Runs one arbitration round starting in an IDLE cycle; returns to the next IDLE cycle.
  // ack_at = grant cycle (1-based) carrying mem_ack; 0 means the memory never answers.
  task automatic xact(input logic ir, input logic dr, input logic dwe,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                      input int ack_at, input logic [31:0] rd, input logic hold,
                      output logic obs_if);
    logic        w_if;
    logic        acked;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;

    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    obs_if      = 1'b0;

    if (!ir && !dr) begin
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom();
      step();
      bus.mem_ack = 1'b0;
      check_eq("idle_mem_req", 32'(bus.mem_req), 32'd0);
      check_eq("idle_dones", 32'({bus.if_done, bus.d_done}), 32'd0);
      return;
    end

    bus.mem_ack = 1'b0;
    w_if = (ir && dr) ? (starve == int'(STARVE_MAX)) : ir;
    if (w_if || !ir) starve = 0;
    else if (starve < 3) starve = starve + 1;

    e_addr  = w_if ? ia : da;
    e_we    = w_if ? 1'b0 : dwe;
    e_wdata = w_if ? 32'd0 : dwd;
    acked   = 1'b0;

    step();
    obs_if = bus.mem_req && (bus.mem_addr == ia) && !bus.mem_we;
    for (int n = 1; n <= int'(TIMEOUT); n++) begin
      check_eq("gnt_mem_req",   32'(bus.mem_req), 32'd1);
      check_eq("gnt_mem_addr",  bus.mem_addr,     e_addr);
      check_eq("gnt_mem_we",    32'(bus.mem_we),  32'(e_we));
      check_eq("gnt_mem_wdata", bus.mem_wdata,    e_wdata);
      check_eq("gnt_dones",     32'({bus.if_done, bus.d_done}), 32'd0);
      // The losing requester's operands wander while the grant is held.
      if (w_if) begin
        bus.d_addr  = $urandom();
        bus.d_wdata = $urandom();
        bus.d_we    = 1'($urandom_range(0, 1));
      end else begin
        bus.if_addr = $urandom();
      end
      if (n == ack_at) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        acked         = 1'b1;
      end else begin
        bus.mem_rdata = $urandom();
      end
      step();
      bus.mem_ack = 1'b0;
      if (acked) break;
    end

    if (w_if) exp_if_rdata = acked ? rd : 32'd0;
    else if (!dwe) exp_d_rdata = acked ? rd : 32'd0;

    check_eq("resp_if_done",  32'(bus.if_done), 32'(w_if));
    check_eq("resp_d_done",   32'(bus.d_done),  32'(!w_if));
    check_eq("resp_err",      32'(bus.err),     32'(!acked));
    check_eq("resp_mem_req",  32'(bus.mem_req), 32'd0);
    check_eq("resp_if_rdata", bus.if_rdata,     exp_if_rdata);
    check_eq("resp_d_rdata",  bus.d_rdata,      exp_d_rdata);

    if (!hold) begin
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
    end
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom();
    step();
    bus.mem_ack = 1'b0;
    check_eq("post_mem_req",  32'(bus.mem_req), 32'd0);
    check_eq("post_dones",    32'({bus.if_done, bus.d_done}), 32'd0);
    check_eq("post_err",      32'(bus.err),     32'd0);
    check_eq("post_if_rdata", bus.if_rdata,     exp_if_rdata);
    check_eq("post_d_rdata",  bus.d_rdata,      exp_d_rdata);
  endtask

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    reset = 1'b1;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    // Fetch example: ack in grant cycle 3
    xact(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 3, 32'h00A0_0093, 1'b0, got_if);
    check_eq("fetch_rdata", bus.if_rdata, 32'h00A0_0093);

    // Load then store: the store must leave d_rdata alone
    xact(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 2, 32'h1234_5678, 1'b0, got_if);
    xact(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 2, 32'hFFFF_FFFF, 1'b0, got_if);
    check_eq("store_keeps_d_rdata", bus.d_rdata, 32'h1234_5678);

    // Contention: both requests held high, grant order D, D, IF, D, D, IF
    order = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      xact(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 32'h5555_AAAA, 1, $urandom(),
           (i != 5), got_if);
      check_eq("contention_order", 32'(got_if), 32'(order[i]));
    end

    // Timeout on a load, then an ack landing exactly on the timeout cycle
    xact(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 0, 32'hCAFE_F00D, 1'b0, got_if);
    check_eq("timeout_d_rdata", bus.d_rdata, 32'd0);
    xact(1'b0, 1'b1, 1'b0, 32'h0, 32'h304, 32'h0, int'(TIMEOUT), 32'hCAFE_F00D, 1'b0, got_if);
    check_eq("ack_at_limit_rdata", bus.d_rdata, 32'hCAFE_F00D);
    xact(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 0, 32'h1, 1'b0, got_if);

    for (int i = 0; i < 60; i++) begin
      int ack_at;
      logic ir, dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ack_at = 0;
      else ack_at = int'($urandom_range(1, TIMEOUT));
      xact(ir, dr, 1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
           ack_at, $urandom(), 1'($urandom_range(0, 1)), got_if);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step();
    step();

    // Reset in the second grant cycle of a fetch drops it without a done pulse
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    step();
    step();
    check_eq("pre_reset_mem_req", 32'(bus.mem_req), 32'd1);
    reset      = 1'b1;
    bus.if_req = 1'b0;
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check_all_zero("midreset");
    reset = 1'b0;
    starve       = 0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    step();
    check_eq("midreset_no_done", 32'({bus.if_done, bus.d_done}), 32'd0);
    xact(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 2, 32'h0BAD_F00D, 1'b0, got_if);
    check_eq("after_reset_fetch", bus.if_rdata, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
